// File: rtl/mc_control_pkg.sv
// Shared types and encodings for the multi-cycle MIPS main control unit.
package mc_control_pkg;

  typedef enum logic [3:0] {
    ST_RESET    = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_EXEC_R   = 4'd3,
    ST_EXEC_I   = 4'd4,
    ST_MEM_ADDR = 4'd5,
    ST_MEM_RD   = 4'd6,
    ST_MEM_WR   = 4'd7,
    ST_WB_R     = 4'd8,
    ST_WB_I     = 4'd9,
    ST_WB_MEM   = 4'd10,
    ST_BRANCH   = 4'd11,
    ST_JUMP     = 4'd12,
    ST_JUMP_REG = 4'd13,
    ST_ERROR    = 4'd14
  } state_e;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Function codes (IR[5:0])
  localparam logic [5:0] FN_JR = 6'h08;

  // ALU operation select, zero-extended onto alu_op
  localparam int unsigned ALUSEL_W = 4;
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_FUNCT = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_AND   = 4'd4;
  localparam logic [3:0] ALU_OR    = 4'd5;
  localparam logic [3:0] ALU_XOR   = 4'd6;
  localparam logic [3:0] ALU_LUI   = 4'd7;
  localparam logic [3:0] ALU_SLTU  = 4'd8;

  // PC source select
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_RS     = 2'b11;

  // Register destination select
  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  // ALU B operand select
  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // States that wait on the memory handshake
  function automatic logic is_wait_state(input state_e s);
    return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
  endfunction

endpackage

// File: rtl/mc_control_mem_timer.sv
// Memory wait counter: counts cycles without ready and flags a timeout.
module mc_mem_timer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  input  logic ready,
  output logic timeout
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear on state entry, otherwise count each enabled cycle without ready
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !ready) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires on the cycle whose missing ready makes the count reach MEM_TIMEOUT
  assign timeout = enable && !ready && (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/mc_control.sv
// Multi-cycle MIPS main control FSM with memory timeout and stall hold.
// Optional performance counters enabled by defining MC_CONTROL_PERF_EN.
module mc_control
  import mc_control_pkg::*;
#(
  parameter int unsigned ALUOP_W     = 5,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  input  logic               stall,
  output logic               pc_we,
  output logic               ir_we,
  output logic               reg_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               mem_to_reg,
  output logic               i_or_d,
  output logic               alu_src_a,
  output logic               is_jal,
  output logic [1:0]         pc_src,
  output logic [1:0]         reg_dst,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [3:0]         state,
  output logic               instr_done,
  output logic               illegal_op,
`ifdef MC_CONTROL_PERF_EN
  output logic [31:0]        cycle_count,
  output logic [31:0]        instr_count,
`endif
  output logic               mem_err
);

  state_e              state_q, state_d;
  logic                mem_err_q, mem_err_d;
  logic [ALUSEL_W-1:0] alu_sel;
  logic                timeout_c;
  logic                tmr_clear_c;
  logic                tmr_enable_c;

  // Wait-cycle counter for the memory handshake
  assign tmr_enable_c = is_wait_state(state_q) && !stall;
  assign tmr_clear_c  = (state_d != state_q);

  mc_mem_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (tmr_clear_c),
    .enable  (tmr_enable_c),
    .ready   (mem_ready),
    .timeout (timeout_c)
  );

  // State and sticky error registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_RESET;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_err_q <= mem_err_d;
    end
  end

  // Next-state and per-state datapath strobes
  always_comb begin
    state_d    = state_q;
    mem_err_d  = mem_err_q | timeout_c;
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    i_or_d     = 1'b0;
    alu_src_a  = 1'b0;
    is_jal     = 1'b0;
    pc_src     = PC_ALU;
    reg_dst    = RD_RT;
    alu_src_b  = SRCB_RT;
    alu_sel    = ALU_ADD;
    instr_done = 1'b0;
    illegal_op = 1'b0;

    case (state_q)
      ST_RESET: state_d = ST_FETCH;
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (timeout_c) begin
          state_d = ST_ERROR;
        end else if (mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        case (opcode)
          OP_RTYPE: state_d = (funct == FN_JR) ? ST_JUMP_REG : ST_EXEC_R;
          OP_ADDI, OP_SLTI, OP_SLTIU, OP_ANDI,
          OP_ORI, OP_XORI, OP_LUI: state_d = ST_EXEC_I;
          OP_LW, OP_SW:            state_d = ST_MEM_ADDR;
          OP_BEQ, OP_BNE:          state_d = ST_BRANCH;
          OP_J, OP_JAL:            state_d = ST_JUMP;
          default: begin
            illegal_op = 1'b1;
            instr_done = 1'b1;
            state_d    = ST_FETCH;
          end
        endcase
      end
      ST_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_sel   = ALU_FUNCT;
        state_d   = ST_WB_R;
      end
      ST_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        case (opcode)
          OP_SLTI:  alu_sel = ALU_SLT;
          OP_SLTIU: alu_sel = ALU_SLTU;
          OP_ANDI:  alu_sel = ALU_AND;
          OP_ORI:   alu_sel = ALU_OR;
          OP_XORI:  alu_sel = ALU_XOR;
          OP_LUI:   alu_sel = ALU_LUI;
          default:  alu_sel = ALU_ADD;
        endcase
        state_d = ST_WB_I;
      end
      ST_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
      end
      ST_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (timeout_c) begin
          state_d = ST_ERROR;
        end else if (mem_ready) begin
          state_d = ST_WB_MEM;
        end
      end
      ST_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (timeout_c) begin
          state_d = ST_ERROR;
        end else if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = ST_FETCH;
        end
      end
      ST_WB_R: begin
        reg_write  = 1'b1;
        reg_dst    = RD_RD;
        instr_done = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_WB_I: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_sel    = ALU_SUB;
        pc_src     = PC_ALUOUT;
        pc_we      = (opcode == OP_BNE) ? !zero : zero;
        instr_done = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_JUMP: begin
        pc_we  = 1'b1;
        pc_src = PC_JUMP;
        if (opcode == OP_JAL) begin
          reg_write = 1'b1;
          reg_dst   = RD_RA;
          is_jal    = 1'b1;
        end
        instr_done = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_JUMP_REG: begin
        pc_we      = 1'b1;
        pc_src     = PC_RS;
        instr_done = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_ERROR;
    endcase

    // Stall or reset suppresses every side-effecting strobe; stall also holds state
    if (stall || !rst_n) begin
      pc_we      = 1'b0;
      ir_we      = 1'b0;
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      mem_read   = 1'b0;
      instr_done = 1'b0;
      illegal_op = 1'b0;
    end
    if (stall) begin
      state_d   = state_q;
      mem_err_d = mem_err_q;
    end
  end

  assign alu_op  = ALUOP_W'(alu_sel);
  assign state   = state_q;
  assign mem_err = mem_err_q;

`ifdef MC_CONTROL_PERF_EN
  logic [31:0] cycle_count_q, cycle_count_d;
  logic [31:0] instr_count_q, instr_count_d;

  // Free-running cycle and retired-instruction counters
  always_comb begin
    cycle_count_d = cycle_count_q + 32'd1;
    instr_count_d = instr_count_q + 32'(instr_done);
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_count_q <= '0;
      instr_count_q <= '0;
    end else begin
      cycle_count_q <= cycle_count_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign cycle_count = cycle_count_q;
  assign instr_count = instr_count_q;
`endif

endmodule

// File: tb/tb_mc_control.sv
// Directed self-checking bench for mc_control.
module tb_mc_control;
  import mc_control_pkg::*;

  localparam int unsigned ALUOP_W = 5;

  logic               clk;
  logic               rst_n;
  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic               zero;
  logic               mem_ready;
  logic               stall;
  logic               pc_we, ir_we, reg_write, mem_read, mem_write;
  logic               mem_to_reg, i_or_d, alu_src_a, is_jal;
  logic [1:0]         pc_src, reg_dst, alu_src_b;
  logic [ALUOP_W-1:0] alu_op;
  logic [3:0]         state;
  logic               instr_done, illegal_op, mem_err;
`ifdef MC_CONTROL_PERF_EN
  logic [31:0]        cycle_count, instr_count;
`endif

  int n_vec = 0;
  int n_err = 0;
  int lat;

  mc_control #(
    .ALUOP_W     (ALUOP_W),
    .MEM_TIMEOUT (15)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .opcode      (opcode),
    .funct       (funct),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .stall       (stall),
    .pc_we       (pc_we),
    .ir_we       (ir_we),
    .reg_write   (reg_write),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_to_reg  (mem_to_reg),
    .i_or_d      (i_or_d),
    .alu_src_a   (alu_src_a),
    .is_jal      (is_jal),
    .pc_src      (pc_src),
    .reg_dst     (reg_dst),
    .alu_src_b   (alu_src_b),
    .alu_op      (alu_op),
    .state       (state),
    .instr_done  (instr_done),
    .illegal_op  (illegal_op),
`ifdef MC_CONTROL_PERF_EN
    .cycle_count (cycle_count),
    .instr_count (instr_count),
`endif
    .mem_err     (mem_err)
  );

  // All outputs packed together; mem_err is bit 0
  logic [22:0] outs;
  assign outs = {pc_we, ir_we, reg_write, mem_read, mem_write, mem_to_reg, i_or_d,
                 alu_src_a, is_jal, pc_src, reg_dst, alu_src_b, alu_op,
                 instr_done, illegal_op, mem_err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard bound on simulation time
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample point is 1ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run one instruction from FETCH; inserts waits cycles of mem_ready=0 in MEM_RD.
  // Returns cycles from FETCH up to and including the instr_done cycle.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int waits, output int n);
    int w;
    w = waits;
    n = 0;
    opcode = op;
    funct  = fn;
    zero   = z;
    for (int i = 0; i < 20; i++) begin
      n++;
      if (state == 4'(ST_MEM_RD) && w > 0) begin
        mem_ready = 1'b0;
        w--;
      end else begin
        mem_ready = 1'b1;
      end
      #1;
      if (instr_done) break;
      step();
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    opcode    = OP_RTYPE;
    funct     = 6'h20;
    zero      = 1'b0;
    mem_ready = 1'b1;
    stall     = 1'b0;

    // Reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_state", 32'(state), 32'(ST_RESET));
      check("rst_outs", 32'(outs), 32'd0);
    end
    rst_n = 1'b1;
    #1;
    check("reset_state_after_release", 32'(state), 32'(ST_RESET));
    check("reset_outs_after_release", 32'(outs), 32'd0);

    // Zero-wait add: FETCH, DECODE, EXEC_R, WB_R
    step();
    check("add_fetch_state", 32'(state), 32'(ST_FETCH));
    check("add_fetch_rd", 32'({mem_read, i_or_d, alu_src_a, alu_src_b}), 32'b10001);
    check("add_fetch_we", 32'({ir_we, pc_we, instr_done}), 32'b110);
    step();
    check("add_decode_state", 32'(state), 32'(ST_DECODE));
    check("add_decode_srcb", 32'({alu_src_a, alu_src_b, alu_op}), 32'b0_11_00000);
    step();
    check("add_exec_state", 32'(state), 32'(ST_EXEC_R));
    check("add_exec_alu", 32'({alu_src_a, alu_src_b, alu_op}), 32'b1_00_00010);
    step();
    check("add_wb_state", 32'(state), 32'(ST_WB_R));
    check("add_wb", 32'({reg_write, reg_dst, instr_done, mem_to_reg}), 32'b1_01_1_0);
    step();
    check("add_back_fetch", 32'(state), 32'(ST_FETCH));

    // lw with two MEM_RD wait cycles
    run_instr(OP_LW, 6'h00, 1'b0, 2, lat);
    check("lw_latency", 32'(lat), 32'd7);
    check("lw_wbmem", 32'({state, reg_write, mem_to_reg, reg_dst}), {24'd0, 4'd10, 4'b1100});
    step();

    // sw and andi zero-wait latencies
    run_instr(OP_SW, 6'h00, 1'b0, 0, lat);
    check("sw_latency", 32'(lat), 32'd4);
    step();
    run_instr(OP_ANDI, 6'h00, 1'b0, 0, lat);
    check("andi_latency", 32'(lat), 32'd4);
    step();

    // xori and sltiu ALU selects
    opcode    = OP_XORI;
    mem_ready = 1'b1;
    #1;
    step();
    step();
    check("xori_exec", 32'({state, alu_src_a, alu_src_b, alu_op}), 32'b0100_1_10_00110);
    step();
    check("xori_wb", 32'({reg_write, reg_dst, instr_done}), 32'b1_00_1);
    step();
    opcode = OP_SLTIU;
    #1;
    step();
    step();
    check("sltiu_alu_op", 32'(alu_op), 32'd8);
    step();
    step();

    // Branches: pc_we follows zero for beq, inverse for bne
    run_instr(OP_BEQ, 6'h00, 1'b1, 0, lat);
    check("beq_taken_latency", 32'(lat), 32'd3);
    check("beq_taken", 32'({pc_we, pc_src, alu_op}), 32'b1_01_00001);
    step();
    run_instr(OP_BEQ, 6'h00, 1'b0, 0, lat);
    check("beq_not_taken", 32'({pc_we, pc_src, instr_done}), 32'b0_01_1);
    step();
    run_instr(OP_BNE, 6'h00, 1'b0, 0, lat);
    check("bne_taken", 32'({pc_we, pc_src}), 32'b1_01);
    step();
    run_instr(OP_BNE, 6'h00, 1'b1, 0, lat);
    check("bne_not_taken", 32'({pc_we, pc_src}), 32'b0_01);
    step();

    // jal, then jr
    run_instr(OP_JAL, 6'h00, 1'b0, 0, lat);
    check("jal_latency", 32'(lat), 32'd3);
    check("jal_state", 32'(state), 32'(ST_JUMP));
    check("jal_strobes", 32'({pc_we, reg_write, reg_dst, is_jal, pc_src}), 32'b1_1_10_1_10);
    step();
    run_instr(OP_RTYPE, FN_JR, 1'b0, 0, lat);
    check("jr_latency", 32'(lat), 32'd3);
    check("jr_state", 32'(state), 32'(ST_JUMP_REG));
    check("jr_strobes", 32'({pc_we, reg_write, pc_src, is_jal}), 32'b1_0_11_0);
    step();
    run_instr(OP_J, 6'h00, 1'b0, 0, lat);
    check("j_strobes", 32'({pc_we, reg_write, is_jal, pc_src}), 32'b1_0_0_10);
    step();

    // sw stalled for two cycles in MEM_WR with ready high
    opcode    = OP_SW;
    mem_ready = 1'b1;
    #1;
    step();
    step();
    step();
    stall = 1'b1;
    #1;
    check("stall1_state", 32'(state), 32'(ST_MEM_WR));
    check("stall1_strobes", 32'({mem_write, mem_read, instr_done, pc_we}), 32'b0000);
    step();
    check("stall2_state", 32'(state), 32'(ST_MEM_WR));
    check("stall2_mem_write", 32'(mem_write), 32'd0);
    step();
    stall = 1'b0;
    #1;
    check("stall_release_state", 32'(state), 32'(ST_MEM_WR));
    check("stall_release_wr", 32'({mem_write, i_or_d, instr_done}), 32'b111);
    step();
    check("sw_back_fetch", 32'(state), 32'(ST_FETCH));

    // Illegal opcode 0x3F
    opcode = 6'h3F;
    #1;
    step();
    check("illegal_pulse", 32'({state, illegal_op, instr_done}), {26'd0, 4'd2, 2'b11});
    step();
    check("illegal_to_fetch", 32'({state, illegal_op}), {27'd0, 4'd1, 1'b0});

    // Memory timeout in FETCH
    mem_ready = 1'b0;
    #1;
    check("to_fetch_wait", 32'({mem_read, ir_we, pc_we}), 32'b100);
    repeat (14) step();
    check("to_boundary_state", 32'(state), 32'(ST_FETCH));
    check("to_boundary_err", 32'(mem_err), 32'd0);
    step();
    check("to_error_state", 32'(state), 32'(ST_ERROR));
    check("to_error_flag", 32'(mem_err), 32'd1);
    mem_ready = 1'b1;
    #1;
    repeat (3) step();
    check("err_hold_state", 32'(state), 32'(ST_ERROR));
    check("err_hold_outs", 32'(outs), 32'd1);

    // Reset clears error
    rst_n = 1'b0;
    step();
    check("err_reset_state", 32'(state), 32'(ST_RESET));
    check("err_reset_outs", 32'(outs), 32'd0);
    rst_n = 1'b1;
    step();
    check("post_reset_fetch", 32'(state), 32'(ST_FETCH));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
